// File: rtl/ifu_bht_update_ctl_pkg.sv
// Shared IFU/EXU types: default BHT geometry and the resolved-branch update packet.
package swerv_types;

    localparam int BHT_ADDR_HI_DFLT = 9;
    localparam int BHT_ADDR_LO_DFLT = 4;
    localparam int BHT_IW           = BHT_ADDR_HI_DFLT - BHT_ADDR_LO_DFLT + 1;
    localparam int BHT_UPD_DEPTH    = 4;

    typedef struct packed {
        logic [1:0]        bank;
        logic [BHT_IW-1:0] index;
        logic [1:0]        hist;
    } bht_upd_pkt_t;

endpackage

// File: rtl/ifu_bht_update_ctl_fifo.sv
// Circular update queue with wrap-bit pointers and a youngest-entry key compare
// used by the parent to decide whether an incoming update can be coalesced.
module bht_upd_fifo #(
    parameter int IW    = 6,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          coal_i,
    input  logic [1:0]    bank_i,
    input  logic [IW-1:0] index_i,
    input  logic [1:0]    hist_i,
    output logic [1:0]    head_bank_o,
    output logic [IW-1:0] head_index_o,
    output logic [1:0]    head_hist_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          one_o,
    output logic          tail_match_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [1:0]       bank_q  [DEPTH];
    logic [IW-1:0]    index_q [DEPTH];
    logic [1:0]       hist_q  [DEPTH];

    logic [AW-1:0] widx, ridx, tidx;

    assign widx = wptr_q[AW-1:0];
    assign ridx = rptr_q[AW-1:0];
    assign tidx = widx - AW'(1);

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign one_o   = ((wptr_q - rptr_q) == PW'(1));

    assign tail_match_o = vld_q[tidx] && (bank_q[tidx] == bank_i) && (index_q[tidx] == index_i);

    assign head_bank_o  = bank_q[ridx];
    assign head_index_o = index_q[ridx];
    assign head_hist_o  = hist_q[ridx];

    // Push after pop so a full-with-pop cycle re-validates the slot just freed.
    always_comb begin
        wptr_d = wptr_q + PW'(push_i);
        rptr_d = rptr_q + PW'(pop_i);
        vld_d  = vld_q;
        if (pop_i)  vld_d[ridx] = 1'b0;
        if (push_i) vld_d[widx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            vld_q  <= vld_d;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            bank_q[widx]  <= bank_i;
            index_q[widx] <= index_i;
            hist_q[widx]  <= hist_i;
        end else if (coal_i) begin
            hist_q[tidx]  <= hist_i;
        end
    end

endmodule

// File: rtl/ifu_bht_update_ctl.sv
// Turns resolved-branch packets into BHT write transactions through a small
// coalescing queue, and keeps free-running update statistics.
module ifu_bht_update_ctl
    import swerv_types::*;
#(
    parameter int BHT_ADDR_HI = BHT_ADDR_HI_DFLT,
    parameter int BHT_ADDR_LO = BHT_ADDR_LO_DFLT,
    parameter int DEPTH       = BHT_UPD_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             br_upd_valid,
    input  logic [BHT_ADDR_HI-BHT_ADDR_LO:0] br_upd_index,
    input  logic [1:0]                       br_upd_bank,
    input  logic [1:0]                       br_upd_hist,
    input  logic                             br_upd_misp,
    input  logic                             br_upd_ataken,
    output logic                             bht_wr_en,
    output logic [BHT_ADDR_HI-BHT_ADDR_LO:0] bht_wr_addr,
    output logic [1:0]                       bht_wr_bank,
    output logic [1:0]                       bht_wr_data,
    input  logic                             bht_wr_ready,
    output logic [31:0]                      upd_cnt,
    output logic [31:0]                      misp_cnt,
    output logic [31:0]                      taken_cnt,
    output logic [31:0]                      drop_cnt,
    output logic                             fifo_full,
    output logic                             fifo_empty
);

    localparam int IW = BHT_ADDR_HI - BHT_ADDR_LO + 1;

    logic pop, push, coal, drop, accept;
    logic full, empty, one, tail_match;

    logic [31:0] upd_cnt_q,   upd_cnt_d;
    logic [31:0] misp_cnt_q,  misp_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] drop_cnt_q,  drop_cnt_d;

    bht_upd_fifo #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_l        (rst_l),
        .push_i       (push),
        .pop_i        (pop),
        .coal_i       (coal),
        .bank_i       (br_upd_bank),
        .index_i      (br_upd_index),
        .hist_i       (br_upd_hist),
        .head_bank_o  (bht_wr_bank),
        .head_index_o (bht_wr_addr),
        .head_hist_o  (bht_wr_data),
        .full_o       (full),
        .empty_o      (empty),
        .one_o        (one),
        .tail_match_o (tail_match)
    );

    assign bht_wr_en  = ~empty;
    assign fifo_full  = full;
    assign fifo_empty = empty;

    // A lone entry leaving this cycle is already committed to the write port,
    // so it cannot absorb a later update.
    assign pop    = ~empty & bht_wr_ready;
    assign coal   = br_upd_valid & tail_match & ~(pop & one);
    assign push   = br_upd_valid & ~coal & (~full | pop);
    assign drop   = br_upd_valid & ~coal & full & ~pop;
    assign accept = coal | push;

    always_comb begin
        upd_cnt_d   = upd_cnt_q   + 32'(accept);
        misp_cnt_d  = misp_cnt_q  + 32'(accept & br_upd_misp);
        taken_cnt_d = taken_cnt_q + 32'(accept & br_upd_ataken);
        drop_cnt_d  = drop_cnt_q  + 32'(drop);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            upd_cnt_q   <= '0;
            misp_cnt_q  <= '0;
            taken_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            upd_cnt_q   <= upd_cnt_d;
            misp_cnt_q  <= misp_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign upd_cnt   = upd_cnt_q;
    assign misp_cnt  = misp_cnt_q;
    assign taken_cnt = taken_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ifu_bht_update_ctl.sv
// Bench for ifu_bht_update_ctl: directed scenarios plus a randomized run, all
// checked against a queue-based model of the update rules.
module tb_ifu_bht_update_ctl;
    import swerv_types::*;

    localparam int IW    = BHT_IW;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          br_upd_valid;
    logic [IW-1:0] br_upd_index;
    logic [1:0]    br_upd_bank;
    logic [1:0]    br_upd_hist;
    logic          br_upd_misp;
    logic          br_upd_ataken;
    logic          bht_wr_en;
    logic [IW-1:0] bht_wr_addr;
    logic [1:0]    bht_wr_bank;
    logic [1:0]    bht_wr_data;
    logic          bht_wr_ready;
    logic [31:0]   upd_cnt, misp_cnt, taken_cnt, drop_cnt;
    logic          fifo_full, fifo_empty;

    ifu_bht_update_ctl #(
        .BHT_ADDR_HI (BHT_ADDR_HI_DFLT),
        .BHT_ADDR_LO (BHT_ADDR_LO_DFLT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .br_upd_valid  (br_upd_valid),
        .br_upd_index  (br_upd_index),
        .br_upd_bank   (br_upd_bank),
        .br_upd_hist   (br_upd_hist),
        .br_upd_misp   (br_upd_misp),
        .br_upd_ataken (br_upd_ataken),
        .bht_wr_en     (bht_wr_en),
        .bht_wr_addr   (bht_wr_addr),
        .bht_wr_bank   (bht_wr_bank),
        .bht_wr_data   (bht_wr_data),
        .bht_wr_ready  (bht_wr_ready),
        .upd_cnt       (upd_cnt),
        .misp_cnt      (misp_cnt),
        .taken_cnt     (taken_cnt),
        .drop_cnt      (drop_cnt),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    bht_upd_pkt_t mq[$];
    int unsigned  m_upd, m_misp, m_taken, m_drop;
    int unsigned  base_upd, base_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        chk("wr_en", 64'(bht_wr_en), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("wr_addr", 64'(bht_wr_addr), 64'(mq[0].index));
            chk("wr_bank", 64'(bht_wr_bank), 64'(mq[0].bank));
            chk("wr_data", 64'(bht_wr_data), 64'(mq[0].hist));
        end
        chk("fifo_full",  64'(fifo_full),  64'(mq.size() == DEPTH));
        chk("fifo_empty", 64'(fifo_empty), 64'(mq.size() == 0));
        chk("upd_cnt",   64'(upd_cnt),   64'(m_upd));
        chk("misp_cnt",  64'(misp_cnt),  64'(m_misp));
        chk("taken_cnt", 64'(taken_cnt), 64'(m_taken));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    endtask

    // Update rules applied to a plain queue of pending writes.
    task automatic model_update(input logic v, input bht_upd_pkt_t p, input logic m,
                                input logic t, input logic rdy);
        int n;
        bit pop, coal, push;
        bht_upd_pkt_t tail;
        n    = mq.size();
        pop  = (n > 0) && rdy;
        coal = 1'b0;
        if (v && n > 0) begin
            tail = mq[n-1];
            coal = (tail.bank == p.bank) && (tail.index == p.index) && !(pop && n == 1);
        end
        push = v && !coal && ((n < DEPTH) || pop);
        if (coal) begin
            tail      = mq[n-1];
            tail.hist = p.hist;
            mq[n-1]   = tail;
        end
        if (pop)  mq.delete(0);
        if (push) mq.push_back(p);
        if (coal || push) begin
            m_upd++;
            if (m) m_misp++;
            if (t) m_taken++;
        end else if (v) begin
            m_drop++;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] bk, input logic [IW-1:0] ix,
                        input logic [1:0] hs, input logic m, input logic t, input logic rdy);
        bht_upd_pkt_t p;
        @(negedge clk);
        br_upd_valid  = v;
        br_upd_bank   = bk;
        br_upd_index  = ix;
        br_upd_hist   = hs;
        br_upd_misp   = m;
        br_upd_ataken = t;
        bht_wr_ready  = rdy;
        #1;
        model_check();
        p.bank  = bk;
        p.index = ix;
        p.hist  = hs;
        model_update(v, p, m, t, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 2'd0, '0, 2'd0, 1'b0, 1'b0, rdy);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        br_upd_valid = 1'b0;
        rst_l        = 1'b0;
        #1;
        mq.delete();
        m_upd = 0; m_misp = 0; m_taken = 0; m_drop = 0;
        chk("rst_wr_en",  64'(bht_wr_en),  64'(0));
        chk("rst_empty",  64'(fifo_empty), 64'(1));
        chk("rst_full",   64'(fifo_full),  64'(0));
        chk("rst_upd",    64'(upd_cnt),    64'(0));
        chk("rst_drop",   64'(drop_cnt),   64'(0));
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l         = 1'b0;
        br_upd_valid  = 1'b0;
        br_upd_bank   = 2'd0;
        br_upd_index  = '0;
        br_upd_hist   = 2'd0;
        br_upd_misp   = 1'b0;
        br_upd_ataken = 1'b0;
        bht_wr_ready  = 1'b0;
        m_upd = 0; m_misp = 0; m_taken = 0; m_drop = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wr_en", 64'(bht_wr_en),  64'(0));
        chk("reset_empty", 64'(fifo_empty), 64'(1));
        chk("reset_full",  64'(fifo_full),  64'(0));
        chk("reset_upd",   64'(upd_cnt),    64'(0));
        chk("reset_misp",  64'(misp_cnt),   64'(0));
        chk("reset_taken", 64'(taken_cnt),  64'(0));
        chk("reset_drop",  64'(drop_cnt),   64'(0));
        @(negedge clk);
        rst_l = 1'b1;

        // Single update, presented the cycle after it is pushed.
        step(1'b1, 2'd1, 6'h05, 2'b11, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("t1_wr_en", 64'(bht_wr_en),   64'(1));
        chk("t1_addr",  64'(bht_wr_addr), 64'h05);
        chk("t1_bank",  64'(bht_wr_bank), 64'(1));
        chk("t1_data",  64'(bht_wr_data), 64'(3));
        chk("t1_upd",   64'(upd_cnt),     64'(1));
        chk("t1_misp",  64'(misp_cnt),    64'(1));
        idle(1'b1);
        chk("t1_empty", 64'(fifo_empty),  64'(1));

        // Three queued updates drain in order.
        for (int i = 1; i <= 3; i++) step(1'b1, 2'd0, 6'(i), 2'(i), 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        chk("t2_hold_addr", 64'(bht_wr_addr), 64'(1));
        for (int i = 1; i <= 3; i++) begin
            idle(1'b1);
            chk("t2_order", 64'(bht_wr_addr), 64'(i));
        end
        idle(1'b0);
        chk("t2_empty", 64'(fifo_empty), 64'(1));

        // Back-to-back updates to one entry coalesce.
        base_upd = m_upd;
        step(1'b1, 2'd2, 6'h07, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 6'h07, 2'b10, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t3_data", 64'(bht_wr_data), 64'(2));
        chk("t3_upd",  64'(upd_cnt - base_upd), 64'(2));
        idle(1'b1);
        idle(1'b0);
        chk("t3_one_entry", 64'(fifo_empty), 64'(1));

        // Overfill with the write port blocked.
        base_upd  = m_upd;
        base_drop = m_drop;
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 2'd3, 6'(8'h10 + i), 2'd1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t4_full", 64'(fifo_full), 64'(1));
        chk("t4_drop", 64'(drop_cnt - base_drop), 64'(2));
        chk("t4_upd",  64'(upd_cnt - base_upd),   64'(DEPTH));

        // Full with a pop in the same cycle still accepts a new update.
        step(1'b1, 2'd0, 6'h20, 2'd2, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("t5_full", 64'(fifo_full), 64'(1));
        chk("t5_drop", 64'(drop_cnt - base_drop), 64'(2));
        chk("t5_head", 64'(bht_wr_addr), 64'h11);
        repeat (DEPTH) idle(1'b1);
        idle(1'b0);
        chk("t5_drained", 64'(fifo_empty), 64'(1));

        // Asynchronous reset with entries queued.
        step(1'b1, 2'd1, 6'h30, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 2'd1, 6'h31, 2'd1, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("t6_pre_wr_en", 64'(bht_wr_en), 64'(1));
        mid_reset();

        // Randomized traffic over a small key space to exercise coalescing and drops.
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            if ((i / 40) % 3 == 1) rdy = ($urandom_range(0, 7) == 0);
            else                   rdy = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 1)), 6'($urandom_range(0, 3)),
                 2'($urandom), 1'($urandom), 1'($urandom), rdy);
            if (i == 300) mid_reset();
        end
        repeat (DEPTH + 1) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
